// File: rtl/mod_reconstruct_pkg.sv
// Shared definitions for the modulus/divide family of blocks.
// Holds the reconstruction FSM state type and the default operand width.
package mod_pkg;

    localparam int MOD_K_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        FIN  = 2'd2
    } mod_rec_state_t;

endpackage

// File: rtl/mod_reconstruct_if.sv
// Request/response bundle for the reconstruction unit.
// The master drives operands and start; the slave returns ready, done, dividend and err.
interface mod_reconstruct_if
    import mod_pkg::*;
#(
    parameter int K = MOD_K_DEFAULT
);
    logic           start;
    logic [K-1:0]   quotient;
    logic [K-1:0]   divisor;
    logic [K-1:0]   remainder;
    logic           ready;
    logic           done;
    logic [2*K-1:0] dividend;
    logic           err;

    modport master (
        output start, quotient, divisor, remainder,
        input  ready, done, dividend, err
    );

    modport slave (
        input  start, quotient, divisor, remainder,
        output ready, done, dividend, err
    );
endinterface

// File: rtl/mod_reconstruct.sv
// Rebuilds dividend = quotient*divisor + remainder with a sequential
// shift-and-add multiplier (one quotient bit per cycle, LSB first).
// A zero divisor is flagged as err and returns dividend = 0.
// Optional build macro MOD_RECONSTRUCT_CHECK_EN: additionally flags a
// non-canonical remainder (remainder >= divisor) as err.
module mod_reconstruct
    import mod_pkg::*;
#(
    parameter int K = MOD_K_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    mod_reconstruct_if.slave bus
);

    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(K - 1);

    mod_rec_state_t   state_q;
    logic [K-1:0]     q_q;
    logic [K-1:0]     b_q;
    logic [2*K-1:0]   acc_q;
    logic [CW-1:0]    cnt_q;
    logic             ready_q;
    logic             done_q;
    logic [2*K-1:0]   dividend_q;
    logic             err_q;

    logic [2*K-1:0]   addend_d;
    logic [2*K-1:0]   acc_d;
    logic             bad_d;

    // Shift-add step for the current quotient bit, plus operand validity check.
    always_comb begin
        addend_d = {{K{1'b0}}, b_q} << cnt_q;
        acc_d    = q_q[cnt_q] ? (acc_q + addend_d) : acc_q;
        bad_d    = (bus.divisor == '0);
`ifdef MOD_RECONSTRUCT_CHECK_EN
        bad_d    = bad_d | (bus.remainder >= bus.divisor);
`endif
    end

    // Control FSM with registered outputs; the whole datapath resets so an
    // aborted op leaves no trace.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            q_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            dividend_q <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        q_q     <= bus.quotient;
                        b_q     <= bus.divisor;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        err_q   <= bad_d;
                        if (bad_d) begin
                            // Error path skips the multiply and reports at once.
                            acc_q      <= '0;
                            dividend_q <= '0;
                            done_q     <= 1'b1;
                            state_q    <= FIN;
                        end else begin
                            acc_q   <= {{K{1'b0}}, bus.remainder};
                            state_q <= MUL;
                        end
                    end
                end
                MUL: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        // Result is published as FIN is entered so done and
                        // dividend are valid together during FIN.
                        dividend_q <= acc_d;
                        done_q     <= 1'b1;
                        state_q    <= FIN;
                    end
                end
                FIN: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready    = ready_q;
    assign bus.done     = done_q;
    assign bus.dividend = dividend_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_mod_reconstruct.sv
// Directed bench for mod_reconstruct with a scoreboard of expected results.
module tb_mod_reconstruct;
    import mod_pkg::*;

    localparam int K = MOD_K_DEFAULT;

    typedef struct packed {
        logic [2*K-1:0] dividend;
        logic           err;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    exp_t sb[$];

    mod_reconstruct_if #(.K(K)) bus ();

    mod_reconstruct #(.K(K)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [K-1:0] q, input logic [K-1:0] b,
                                   input logic [K-1:0] r);
        exp_t e;
        int   prod;
        e.err = (b == 0);
`ifdef MOD_RECONSTRUCT_CHECK_EN
        if (r >= b) e.err = 1'b1;
`endif
        prod = int'(q) * int'(b) + int'(r);
        e.dividend = e.err ? '0 : prod[2*K-1:0];
        return e;
    endfunction

    // Compare the DUT result against the oldest scoreboard entry.
    task automatic pop_and_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_dividend"}, 32'(bus.dividend), 32'(e.dividend));
            chk({tag, "_err"}, 32'(bus.err), 32'(e.err));
        end
    endtask

    // Issue one op from an IDLE cycle (entered #1 after a rising edge) and
    // follow it to done, checking latency, ready-low time and the result.
    task automatic run_op(input string tag, input logic [K-1:0] q,
                          input logic [K-1:0] b, input logic [K-1:0] r);
        exp_t e;
        int   lat;
        int   rdy_low;
        bit   seen;
        e = model(q, b, r);
        sb.push_back(e);
        bus.start     = 1'b1;
        bus.quotient  = q;
        bus.divisor   = b;
        bus.remainder = r;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0; rdy_low = 0; seen = 1'b0;
        while (!seen && lat < 20) begin
            lat++;
            if (!bus.ready) rdy_low++;
            if (bus.done) seen = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"}, 32'(lat), e.err ? 32'd1 : 32'(K + 1));
        chk({tag, "_ready_low"}, 32'(rdy_low), e.err ? 32'd1 : 32'(K + 1));
        pop_and_check(tag);
        @(posedge clk); #1;
        chk({tag, "_done_single"}, 32'(bus.done), 32'd0);
        chk({tag, "_ready_back"}, 32'(bus.ready), 32'd1);
        chk({tag, "_hold"}, 32'(bus.dividend), 32'(e.dividend));
    endtask

    initial begin
        int   dones;
        exp_t e;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.start     = 1'b0;
        bus.quotient  = '0;
        bus.divisor   = '0;
        bus.remainder = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_dividend", 32'(bus.dividend), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed ops: basic, max canonical, zero divisor, non-canonical remainder
        run_op("t1", 4'd1, 4'd10, 4'd5);
        chk("t1_value", 32'(bus.dividend), 32'd15);
        run_op("t2", 4'd15, 4'd15, 4'd14);
        chk("t2_value", 32'(bus.dividend), 32'd239);
        run_op("t3", 4'd7, 4'd0, 4'd3);
        chk("t3_err", 32'(bus.err), 32'd1);
        run_op("t4", 4'd2, 4'd10, 4'd12);
`ifdef MOD_RECONSTRUCT_CHECK_EN
        chk("t4_value", 32'(bus.dividend), 32'd0);
`else
        chk("t4_value", 32'(bus.dividend), 32'd32);
`endif

        // Start pulsed during MUL must be ignored
        e = model(4'd3, 4'd3, 4'd0);
        sb.push_back(e);
        bus.start = 1'b1; bus.quotient = 4'd3; bus.divisor = 4'd3; bus.remainder = 4'd0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        dones = 0;
        for (int c = 1; c <= 14; c++) begin
            if (c == 2) begin
                bus.start = 1'b1; bus.quotient = 4'd1; bus.divisor = 4'd1;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                dones++;
                pop_and_check("t5");
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        chk("t5_done_count", 32'(dones), 32'd1);
        chk("t5_value", 32'(bus.dividend), 32'd9);

        // Reset mid-op aborts with no done pulse
        bus.start = 1'b1; bus.quotient = 4'd5; bus.divisor = 4'd6; bus.remainder = 4'd1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ready", 32'(bus.ready), 32'd1);
        chk("t6_rst_done", 32'(bus.done), 32'd0);
        chk("t6_rst_dividend", 32'(bus.dividend), 32'd0);
        chk("t6_rst_err", 32'(bus.err), 32'd0);
        dones = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        chk("t6_no_done", 32'(dones), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("t6", 4'd5, 4'd6, 4'd1);
        chk("t6_value", 32'(bus.dividend), 32'd31);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
